// File: rtl/trng_postproc.sv
// -----------------------------------------------------------------------------
// trng_postproc
//
// Post-processing stage for the ring-oscillator entropy source. The raw bit is
// synchronised, decimated by SAMPLE_DIV, checked by a repetition-count health
// test, debiased with a von Neumann corrector and packed MSB-first into bytes.
// Completed bytes go into a small FIFO and are read through valid/ready.
//
// Parameters
//   SAMPLE_DIV  : one raw sample every SAMPLE_DIV clocks (>= 1)
//   RCT_CUTOFF  : identical consecutive samples that trip the health test (2..255)
//   FIFO_DEPTH  : byte FIFO depth (power of two, >= 2)
//
// Ports
//   clk         : clock, all state on the rising edge
//   rst         : asynchronous active-high reset
//   en          : sampling enable; low holds the divider and drops partial state
//   raw_in      : asynchronous raw entropy bit
//   clear_fail  : one-cycle pulse, clears health_fail and overflow
//   data_out    : FIFO head byte
//   data_valid  : FIFO non-empty
//   data_ready  : consumer takes data_out this cycle
//   fifo_count  : number of bytes held
//   health_fail : sticky repetition-count failure
//   overflow    : sticky, a completed byte was dropped on a full FIFO
// -----------------------------------------------------------------------------
module trng_postproc #(
   parameter int SAMPLE_DIV = 4,
   parameter int RCT_CUTOFF = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en,
   input  logic                          raw_in,
   input  logic                          clear_fail,
   output logic [7:0]                    data_out,
   output logic                          data_valid,
   input  logic                          data_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          health_fail,
   output logic                          overflow
);

   localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int RUN_W = 8;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
   localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(RCT_CUTOFF);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

   typedef enum logic {
      PAIR_IDLE,
      PAIR_HAVE_FIRST
   } pair_state_t;

   // ---------------------------------------------------------------------------
   // Two-flop synchroniser
   // ---------------------------------------------------------------------------
   logic r_s1;
   logic r_s2;

   // NOTE: sequential state uses non-blocking (<=) so every flop samples the
   // pre-edge value of its neighbours; blocking here would collapse the chain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
      end else begin
         r_s1 <= raw_in;
         r_s2 <= r_s1;
      end
   end

   // ---------------------------------------------------------------------------
   // Sample divider
   // ---------------------------------------------------------------------------
   logic [DIV_W-1:0] r_div_cnt;
   logic             w_strobe;

   assign w_strobe = en && (r_div_cnt == DIV_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_div_cnt <= '0;
      end else if (!en || (r_div_cnt == DIV_LAST)) begin
         r_div_cnt <= '0;
      end else begin
         r_div_cnt <= r_div_cnt + 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Repetition-count health test
   // ---------------------------------------------------------------------------
   logic [RUN_W-1:0] r_run_cnt;
   logic             r_last_bit;
   logic [RUN_W-1:0] w_run_next;
   logic             w_trip;

   // A run count of 0 marks "no previous sample" (after reset, en drop or
   // clear_fail), so the next sample always starts a fresh run at 1.
   always_comb begin
      w_run_next = r_run_cnt;
      if ((r_run_cnt == '0) || (r_s2 != r_last_bit)) begin
         w_run_next = RUN_W'(1);
      end else if (r_run_cnt < RUN_MAX) begin
         w_run_next = r_run_cnt + 1'b1;
      end
   end

   // clear_fail wins over a trip on the same edge.
   assign w_trip = w_strobe && (w_run_next == RUN_MAX) && !clear_fail;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_run_cnt  <= '0;
         r_last_bit <= 1'b0;
      end else if (clear_fail || !en) begin
         r_run_cnt  <= '0;
      end else if (w_strobe) begin
         r_run_cnt  <= w_run_next;
         r_last_bit <= r_s2;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         health_fail <= 1'b0;
      end else if (clear_fail) begin
         health_fail <= 1'b0;
      end else if (w_trip) begin
         health_fail <= 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Von Neumann corrector
   // ---------------------------------------------------------------------------
   pair_state_t r_pair_state;
   pair_state_t w_pair_next;
   logic        r_first_bit;
   logic        w_vn_active;
   logic        w_flush;
   logic        w_emit;

   // Debiasing is frozen while the health test is failed; a trip or en drop
   // discards any half pair and partial byte.
   assign w_vn_active = w_strobe && !health_fail;
   assign w_flush     = w_trip || !en;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pair_state <= PAIR_IDLE;
         r_first_bit  <= 1'b0;
      end else begin
         r_pair_state <= w_pair_next;
         if (w_vn_active && (r_pair_state == PAIR_IDLE)) begin
            r_first_bit <= r_s2;
         end
      end
   end

   // NOTE: every always_comb output gets a default before any branch, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      w_pair_next = r_pair_state;
      w_emit      = 1'b0;
      if (w_flush) begin
         w_pair_next = PAIR_IDLE;
      end else if (w_vn_active) begin
         case (r_pair_state)
            PAIR_IDLE: begin
               w_pair_next = PAIR_HAVE_FIRST;
            end
            PAIR_HAVE_FIRST: begin
               w_pair_next = PAIR_IDLE;
               w_emit      = (r_s2 != r_first_bit);
            end
            default: begin
               w_pair_next = PAIR_IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Byte assembly: emitted bit enters at the LSB, so the first bit ends as MSB.
   // The push request is registered, so the FIFO write lands one edge after the
   // 8th bit; r_byte cannot change in between because a new emit needs two
   // further strobes.
   // ---------------------------------------------------------------------------
   logic [7:0] r_byte;
   logic [2:0] r_bit_cnt;
   logic       r_push;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_byte    <= 8'h00;
         r_bit_cnt <= 3'd0;
         r_push    <= 1'b0;
      end else begin
         r_push <= w_emit && (r_bit_cnt == 3'd7);
         if (w_flush) begin
            r_byte    <= 8'h00;
            r_bit_cnt <= 3'd0;
         end else if (w_emit) begin
            r_byte    <= {r_byte[6:0], r_first_bit};
            r_bit_cnt <= r_bit_cnt + 3'd1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Byte FIFO
   // ---------------------------------------------------------------------------
   logic [7:0]       r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_pop;
   logic             w_push;
   logic             w_full;
   logic             w_wr_ok;

   assign w_pop   = data_valid && data_ready;
   assign w_push  = r_push && !health_fail;
   assign w_full  = (r_count == CNT_FULL);
   // On a full FIFO a write is still accepted when the head leaves this cycle.
   assign w_wr_ok = w_push && (!w_full || w_pop);

   // NOTE: the storage is reset along with the control state so data_out reads
   // 8'h00 out of reset; at this depth the reset fan-out is negligible.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_mem[i] <= 8'h00;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         overflow <= 1'b0;
      end else begin
         if (clear_fail) begin
            overflow <= 1'b0;
         end
         if (w_trip) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
         end else begin
            if (w_wr_ok) begin
               r_mem[r_wr_ptr] <= r_byte;
               r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_push && !w_wr_ok) begin
               overflow <= 1'b1;
            end
            if (w_pop) begin
               r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_ok, w_pop})
               2'b10:   r_count <= r_count + 1'b1;
               2'b01:   r_count <= r_count - 1'b1;
               default: r_count <= r_count;
            endcase
         end
      end
   end

   assign data_out   = r_mem[r_rd_ptr];
   assign data_valid = (r_count != '0);
   assign fifo_count = r_count;

endmodule

// File: tb/tb_trng_postproc.sv
// -----------------------------------------------------------------------------
// tb_trng_postproc
//
// Directed bench for trng_postproc. Instance dut runs with SAMPLE_DIV=1 for the
// debias, backpressure, health, enable and reset cases; instance dut4 runs with
// SAMPLE_DIV=4 for the divider timing case. Inputs are driven and outputs are
// sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_trng_postproc;

   logic       clk;
   logic       rst;
   logic       en;
   logic       raw_in;
   logic       clear_fail;
   logic       data_ready;
   logic [7:0] data_out;
   logic       data_valid;
   logic [2:0] fifo_count;
   logic       health_fail;
   logic       overflow;

   logic       en4;
   logic       raw4;
   logic       clear4;
   logic       ready4;
   logic [7:0] data_out4;
   logic       valid4;
   logic [2:0] count4;
   logic       fail4;
   logic       ovf4;

   int n_cmp = 0;
   int n_bad = 0;

   bit stream_q[$];

   trng_postproc #(.SAMPLE_DIV(1), .RCT_CUTOFF(32), .FIFO_DEPTH(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .raw_in      (raw_in),
      .clear_fail  (clear_fail),
      .data_out    (data_out),
      .data_valid  (data_valid),
      .data_ready  (data_ready),
      .fifo_count  (fifo_count),
      .health_fail (health_fail),
      .overflow    (overflow)
   );

   trng_postproc #(.SAMPLE_DIV(4), .RCT_CUTOFF(32), .FIFO_DEPTH(4)) dut4 (
      .clk         (clk),
      .rst         (rst),
      .en          (en4),
      .raw_in      (raw4),
      .clear_fail  (clear4),
      .data_out    (data_out4),
      .data_valid  (valid4),
      .data_ready  (ready4),
      .fifo_count  (count4),
      .health_fail (fail4),
      .overflow    (ovf4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Append one byte as von Neumann pairs, MSB first: 1 -> "10", 0 -> "01".
   task automatic add_byte(input logic [7:0] v);
      for (int b = 7; b >= 0; b--) begin
         stream_q.push_back(v[b]);
         stream_q.push_back(!v[b]);
      end
   endtask

   task automatic add_bits(input bit b, input int n);
      for (int i = 0; i < n; i++) stream_q.push_back(b);
   endtask

   // Drive stream_q one bit per clock on dut. en rises with bit 2 so the first
   // strobe samples bit 0 out of the synchroniser. Bit i is strobed at edge
   // i+3; en drops after the last strobe, and a final 8th bit pushes one edge
   // later, where data_ready can optionally be pulsed.
   task automatic send_stream(input bit pop_at_push);
      for (int i = 0; i < stream_q.size(); i++) begin
         raw_in = stream_q[i];
         if (i == 2) en = 1'b1;
         @(negedge clk);
      end
      @(negedge clk);
      @(negedge clk);
      en = 1'b0;
      if (pop_at_push) data_ready = 1'b1;
      @(negedge clk);
      data_ready = 1'b0;
      @(negedge clk);
      stream_q.delete();
   endtask

   task automatic pop_one(input string tag, input logic [7:0] exp);
      check({tag, "_valid"}, data_valid, 1'b1);
      check({tag, "_data"}, data_out, exp);
      data_ready = 1'b1;
      @(negedge clk);
      data_ready = 1'b0;
   endtask

   task automatic pulse_clear();
      clear_fail = 1'b1;
      @(negedge clk);
      clear_fail = 1'b0;
      @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_data_out"}, data_out, 8'h00);
      check({tag, "_valid"}, data_valid, 1'b0);
      check({tag, "_count"}, fifo_count, 3'd0);
      check({tag, "_hfail"}, health_fail, 1'b0);
      check({tag, "_ovf"}, overflow, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst        = 1'b1;
      en         = 1'b0;
      raw_in     = 1'b0;
      clear_fail = 1'b0;
      data_ready = 1'b0;
      en4        = 1'b0;
      raw4       = 1'b0;
      clear4     = 1'b0;
      ready4     = 1'b0;

      // ---- reset values ----
      @(negedge clk);
      check_reset_outputs("rst_hold");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("rst_release");

      // ---- debias / pack: 10,00,01,10,11,10,01,01,10,01 -> 1011_0010 ----
      stream_q = '{1,0, 0,0, 0,1, 1,0, 1,1, 1,0, 0,1, 0,1, 1,0, 0,1};
      send_stream(1'b0);
      check("vn_count", fifo_count, 3'd1);
      pop_one("vn_byte", 8'hB2);
      check("vn_empty", data_valid, 1'b0);

      // ---- backpressure: 5 bytes into depth 4 ----
      for (int k = 1; k <= 5; k++) add_byte(8'(k));
      send_stream(1'b0);
      check("bp_count", fifo_count, 3'd4);
      check("bp_ovf", overflow, 1'b1);
      for (int k = 1; k <= 4; k++) pop_one("bp_read", 8'(k));
      check("bp_empty", data_valid, 1'b0);
      pulse_clear();
      check("bp_ovf_clr", overflow, 1'b0);

      // ---- health test ----
      add_byte(8'hA5);
      add_byte(8'h3C);
      send_stream(1'b0);
      check("rct_queued", fifo_count, 3'd2);
      add_bits(1'b1, 31);
      send_stream(1'b0);
      check("rct_31_hfail", health_fail, 1'b0);
      check("rct_31_count", fifo_count, 3'd2);
      add_bits(1'b1, 32);
      send_stream(1'b0);
      check("rct_32_hfail", health_fail, 1'b1);
      check("rct_32_count", fifo_count, 3'd0);
      check("rct_32_valid", data_valid, 1'b0);
      add_byte(8'h5A);
      send_stream(1'b0);
      check("rct_blocked", fifo_count, 3'd0);
      pulse_clear();
      check("rct_cleared", health_fail, 1'b0);
      add_byte(8'hC3);
      send_stream(1'b0);
      check("rct_resume_cnt", fifo_count, 3'd1);
      pop_one("rct_resume", 8'hC3);

      // ---- enable drop: 5 emitted bits then en low, then a fresh byte ----
      for (int i = 0; i < 5; i++) add_byte_bit1();
      send_stream(1'b0);
      check("en_partial", fifo_count, 3'd0);
      add_byte(8'h4D);
      send_stream(1'b0);
      check("en_count", fifo_count, 3'd1);
      pop_one("en_byte", 8'h4D);

      // ---- push and pop on the same edge while full ----
      for (int k = 1; k <= 5; k++) add_byte(8'(k * 8'h11));
      send_stream(1'b1);
      check("pp_count", fifo_count, 3'd4);
      check("pp_ovf", overflow, 1'b0);
      for (int k = 2; k <= 5; k++) pop_one("pp_read", 8'(k * 8'h11));
      check("pp_empty", data_valid, 1'b0);

      // ---- divider on dut4: strobes at edges 4,8,..,64; push at edge 65 ----
      stream_q.delete();
      add_byte(8'h96);
      for (int s = 0; s < 64; s++) begin
         raw4 = stream_q[s / 4];
         if (s == 0) en4 = 1'b1;
         @(negedge clk);
      end
      en4 = 1'b0;
      stream_q.delete();
      check("div_not_early", valid4, 1'b0);
      @(negedge clk);
      check("div_valid", valid4, 1'b1);
      check("div_byte", data_out4, 8'h96);
      check("div_count", count4, 3'd1);

      // ---- reset mid-stream with 2 bytes queued ----
      add_byte(8'hE1);
      add_byte(8'h7E);
      send_stream(1'b0);
      check("mrst_queued", fifo_count, 3'd2);
      for (int i = 0; i < 6; i++) begin
         raw_in = (i % 3 == 0);
         en     = 1'b1;
         @(negedge clk);
      end
      #2 rst = 1'b1;
      #1;
      check_reset_outputs("mrst_now");
      @(negedge clk);
      rst = 1'b0;
      en  = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("mrst_idle_valid", data_valid, 1'b0);
      end
      add_byte(8'h69);
      send_stream(1'b0);
      check("mrst_fresh_cnt", fifo_count, 3'd1);
      pop_one("mrst_fresh", 8'h69);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // One emitted '1' bit as a "10" pair.
   task automatic add_byte_bit1();
      stream_q.push_back(1'b1);
      stream_q.push_back(1'b0);
   endtask

endmodule
